// File: rtl/id_ex_stage.sv
// ID/EX pipeline boundary: applies the writeback-to-decode bypass to the register file
// read data, detects load-use hazards against the held instruction, and inserts bubbles.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [RA_W-1:0]  in_rs1,
    input  logic [RA_W-1:0]  in_rs2,
    input  logic [RA_W-1:0]  in_rd,
    input  logic             in_uses_rs1,
    input  logic             in_uses_rs2,
    input  logic [XLEN-1:0]  in_rd1,
    input  logic [XLEN-1:0]  in_rd2,
    input  logic [XLEN-1:0]  in_imm,
    input  logic             in_regwrite,
    input  logic             in_memread,
    input  logic             in_memwrite,
    input  logic             in_jal,
    input  logic             in_alu_src,
    input  logic [3:0]       in_alu_op,
    input  logic             wb_regwrite,
    input  logic [RA_W-1:0]  wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             flush,
    output logic             stall,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_op1,
    output logic [XLEN-1:0]  ex_op2,
    output logic [XLEN-1:0]  ex_imm,
    output logic [RA_W-1:0]  ex_rs1,
    output logic [RA_W-1:0]  ex_rs2,
    output logic [RA_W-1:0]  ex_rd,
    output logic             ex_regwrite,
    output logic             ex_memread,
    output logic             ex_memwrite,
    output logic             ex_jal,
    output logic             ex_alu_src,
    output logic [3:0]       ex_alu_op,
    output logic [CNT_W-1:0] stall_count
);

    logic [XLEN-1:0]  op1_n, op2_n;
    logic             hazard;

    logic             valid_q, valid_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  op1_q, op1_d;
    logic [XLEN-1:0]  op2_q, op2_d;
    logic [XLEN-1:0]  imm_q, imm_d;
    logic [RA_W-1:0]  rs1_q, rs1_d;
    logic [RA_W-1:0]  rs2_q, rs2_d;
    logic [RA_W-1:0]  rd_q, rd_d;
    logic             regwrite_q, regwrite_d;
    logic             memread_q, memread_d;
    logic             memwrite_q, memwrite_d;
    logic             jal_q, jal_d;
    logic             alu_src_q, alu_src_d;
    logic [3:0]       alu_op_q, alu_op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // x0 reads as zero; otherwise a same-cycle writeback overrides the stale read data.
    always_comb begin
        op1_n = in_rd1;
        if (in_rs1 == '0) begin
            op1_n = '0;
        end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == in_rs1)) begin
            op1_n = wb_data;
        end

        op2_n = in_rd2;
        if (in_rs2 == '0) begin
            op2_n = '0;
        end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == in_rs2)) begin
            op2_n = wb_data;
        end
    end

    assign hazard = valid_q && memread_q && (rd_q != '0) && in_valid &&
                    ((in_uses_rs1 && (in_rs1 == rd_q)) ||
                     (in_uses_rs2 && (in_rs2 == rd_q)));

    // A flush kills the decoding instruction, so holding it upstream would be pointless.
    assign stall = hazard && !flush;

    // Bubble is the all-zero default; only the capture path loads real values.
    always_comb begin
        valid_d    = 1'b0;
        pc_d       = '0;
        op1_d      = '0;
        op2_d      = '0;
        imm_d      = '0;
        rs1_d      = '0;
        rs2_d      = '0;
        rd_d       = '0;
        regwrite_d = 1'b0;
        memread_d  = 1'b0;
        memwrite_d = 1'b0;
        jal_d      = 1'b0;
        alu_src_d  = 1'b0;
        alu_op_d   = '0;
        cnt_d      = cnt_q;

        if (flush) begin
            cnt_d = cnt_q;
        end else if (hazard) begin
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        end else begin
            valid_d = in_valid;
            pc_d    = in_pc;
            op1_d   = op1_n;
            op2_d   = op2_n;
            imm_d   = in_imm;
            rs1_d   = in_rs1;
            rs2_d   = in_rs2;
            rd_d    = in_rd;
            if (in_valid) begin
                regwrite_d = in_regwrite;
                memread_d  = in_memread;
                memwrite_d = in_memwrite;
                jal_d      = in_jal;
                alu_src_d  = in_alu_src;
                alu_op_d   = in_alu_op;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            op1_q      <= '0;
            op2_q      <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            jal_q      <= 1'b0;
            alu_src_q  <= 1'b0;
            alu_op_q   <= '0;
            cnt_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            jal_q      <= jal_d;
            alu_src_q  <= alu_src_d;
            alu_op_q   <= alu_op_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_pc       = pc_q;
    assign ex_op1      = op1_q;
    assign ex_op2      = op2_q;
    assign ex_imm      = imm_q;
    assign ex_rs1      = rs1_q;
    assign ex_rs2      = rs2_q;
    assign ex_rd       = rd_q;
    assign ex_regwrite = regwrite_q;
    assign ex_memread  = memread_q;
    assign ex_memwrite = memwrite_q;
    assign ex_jal      = jal_q;
    assign ex_alu_src  = alu_src_q;
    assign ex_alu_op   = alu_op_q;
    assign stall_count = cnt_q;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline stage fed directly by the pipelined register file's two read ports.
- Applies a writeback-to-decode bypass to the read operands.
- Detects load-use hazards against the instruction it currently holds, and inserts bubbles.
- Registers operands and control into the ID/EX boundary consumed by the ALU/forwarding stage, and exports a stall to hold IF/ID.

Parameters:
XLEN, 32, datapath width
RA_W, 5, register address width
CNT_W, 16, width of saturating stall counter

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset
in_valid  in  1  IF/ID holds a real instruction
in_pc  in  XLEN  PC of decoding instruction
in_rs1, in_rs2, in_rd  in  RA_W each  register specifiers
in_uses_rs1, in_uses_rs2  in  1 each  instruction actually reads rs1/rs2
in_rd1, in_rd2  in  XLEN each  register file read_data1/read_data2
in_imm  in  XLEN  decoded immediate
in_regwrite, in_memread, in_memwrite, in_jal, in_alu_src  in  1 each  decoded control
in_alu_op  in  4  ALU operation
wb_regwrite  in  1  writeback stage writes the register file this cycle
wb_rd  in  RA_W  writeback destination
wb_data  in  XLEN  writeback value
flush  in  1  taken branch/jump resolved in EX; kill decoding instruction
stall  out  1  hold PC and IF/ID this cycle (combinational)
ex_valid  out  1  ID/EX holds a real instruction
ex_pc, ex_op1, ex_op2, ex_imm  out  XLEN each  registered PC, operands, immediate
ex_rs1, ex_rs2, ex_rd  out  RA_W each  registered specifiers
ex_regwrite, ex_memread, ex_memwrite, ex_jal, ex_alu_src  out  1 each  registered control
ex_alu_op  out  4  registered ALU op
stall_count  out  CNT_W  count of load-use bubbles inserted

Behaviour:
- Reset:
  - On any rising edge with reset==0, every ex_* output and stall_count become 0, with priority over all else.
  - stall is 0 whenever ex_valid==0, so it is 0 after reset.
- Bypass (combinational):
  - op1_n = 0 if in_rs1==0.
  - Otherwise op1_n = wb_data if wb_regwrite && wb_rd!=0 && wb_rd==in_rs1.
  - Otherwise op1_n = in_rd1.
  - op2_n is computed identically from rs2/in_rd2.
  - When both sources match wb_rd, both are bypassed.
- Hazard (combinational):
  - hazard = ex_valid && ex_memread && ex_rd!=0 && in_valid && ((in_uses_rs1 && in_rs1==ex_rd) || (in_uses_rs2 && in_rs2==ex_rd)).
  - stall = hazard && !flush.
- Clocked update, with reset high, in priority order:
  1. flush==1: insert bubble. stall_count is unchanged.
  2. hazard==1: insert bubble; stall_count += 1, saturating at all-ones. Upstream holds the instruction, so it is re-presented next cycle. The bubble has ex_memread=0, so the hazard clears and the instruction issues on the following edge (exactly one bubble per load-use).
  3. Otherwise: capture. ex_valid<=in_valid; ex_pc/imm/rs*/rd/control take the in_* values; ex_op1<=op1_n, ex_op2<=op2_n.
- Bubble definition: ex_valid=0, and every other ex_* field is 0.
- in_valid==0 in the capture path yields ex_valid=0 with control fields forced to 0; data fields are still captured.
- Latency: one cycle from decode inputs to ex_* outputs.
- No handshake beyond stall.
- flush and hazard in the same cycle: flush wins, stall=0, no count.
- A reset deasserted mid-stream restarts with an empty stage.

Test Plan:
- Reset: reset=0 for 2 edges with random inputs -> all ex_* =0, stall=0, stall_count=0.
- Plain capture: in_pc=0x100, rs1=3, rs2=4, in_rd1=30, in_rd2=40, regwrite=1, wb_regwrite=0 -> next edge ex_op1=30, ex_op2=40, ex_pc=0x100, ex_valid=1.
- WB bypass + x0:
  - wb_regwrite=1, wb_rd=3, wb_data=0xDEAD, rs1=3, in_rd1=30 -> ex_op1=0xDEAD.
  - rs2=0, wb_rd=0 -> ex_op2=0.
- Load-use:
  - Cycle 0: capture load with rd=5, memread=1.
  - Cycle 1: add with rs2=5, uses_rs2=1 -> stall=1 during cycle 1; bubble (ex_valid=0) at edge 2; stall_count=1.
  - The add is captured at edge 3.
- Flush priority: same setup as load-use, plus flush=1 in cycle 1 -> stall=0, bubble, stall_count stays 0.
- Counter saturation: force 2^CNT_W+3 consecutive hazards with CNT_W=4 -> stall_count holds 0xF.
